// File: rtl/disp_pkg.sv
// Shared encodings for the display-bus scan monitor: FSM states, digit indices,
// anode idle level and the decoded-anode record.
package disp_pkg;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [1:0] D3 = 2'd3;
  localparam logic [1:0] D2 = 2'd2;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D0 = 2'd0;

  localparam logic AN_IDLE = 1'b1;

  typedef struct packed {
    logic       one;
    logic       multi;
    logic [1:0] idx;
  } anode_t;

  // Number of asserted anodes, saturated at 2 since only "two or more" matters.
  function automatic logic [1:0] count_low(input logic [3:0] low);
    logic [2:0] sum;
    sum = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
    if (sum >= 3'd2) begin
      count_low = 2'd2;
    end else begin
      count_low = sum[1:0];
    end
  endfunction

endpackage

// File: rtl/anode_decode.sv
// Combinational decode of the four active-low anodes into blank / single digit
// index / multiple-anode fault.
module anode_decode
  import disp_pkg::*;
(
  input  logic       an3,
  input  logic       an2,
  input  logic       an1,
  input  logic       an0,
  output logic [1:0] idx,
  output logic       one,
  output logic       multi
);

  logic [3:0] low_s;
  anode_t     dec_s;

  assign low_s = {an3, an2, an1, an0} ^ {4{AN_IDLE}};

  // Classify the anode pattern; idx is only meaningful when exactly one is low.
  always_comb begin
    dec_s = '0;
    case (count_low(low_s))
      2'd0: begin
        dec_s.one   = 1'b0;
        dec_s.multi = 1'b0;
      end
      2'd1: begin
        dec_s.one   = 1'b1;
        dec_s.multi = 1'b0;
      end
      default: begin
        dec_s.one   = 1'b0;
        dec_s.multi = 1'b1;
      end
    endcase
    case (low_s)
      4'b1000: dec_s.idx = D3;
      4'b0100: dec_s.idx = D2;
      4'b0010: dec_s.idx = D1;
      4'b0001: dec_s.idx = D0;
      default: dec_s.idx = D0;
    endcase
  end

  assign idx   = dec_s.idx;
  assign one   = dec_s.one;
  assign multi = dec_s.multi;

endmodule

// File: rtl/display_scan_capture.sv
// Receive-side monitor of the multiplexed 4-digit display bus: settles and
// captures each digit, rebuilds the displayed word and flags scan faults.
module display_scan_capture
  import disp_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic [3:0]  char,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        overlap_err,
  output logic        order_err,
  output logic        timeout_err
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);
  localparam logic [TW-1:0] TMO_C    = TW'(TIMEOUT);

  logic [1:0]    idx_s;
  logic          one_s;
  logic          multi_s;

  logic [3:0]    low_cnt_r;
  logic [3:0]    low_cnt_nxt_s;
  logic [1:0]    prev_idx_r;
  logic          armed_r;
  logic          armed_nxt_s;
  logic          capture_s;

  logic [0:0]    state_r;
  logic [0:0]    state_nxt_s;
  logic [1:0]    expect_r;
  logic [1:0]    expect_nxt_s;
  logic [TW-1:0] tmo_r;
  logic [TW-1:0] tmo_nxt_s;
  logic [TW-1:0] tmo_inc_s;

  logic [3:0]    slot3_r;
  logic [3:0]    slot2_r;
  logic [3:0]    slot1_r;
  logic [3:0]    slot3_nxt_s;
  logic [3:0]    slot2_nxt_s;
  logic [3:0]    slot1_nxt_s;

  logic [15:0]   digits_r;
  logic [15:0]   digits_nxt_s;
  logic          valid_r;
  logic          valid_nxt_s;
  logic          overlap_r;
  logic          overlap_nxt_s;
  logic          order_r;
  logic          order_nxt_s;
  logic          timeout_r;
  logic          timeout_nxt_s;

  anode_decode u_decode (
    .an3   (an3),
    .an2   (an2),
    .an1   (an1),
    .an0   (an0),
    .idx   (idx_s),
    .one   (one_s),
    .multi (multi_s)
  );

  // Settle counter: consecutive cycles of the same single anode, saturating at SETTLE.
  always_comb begin
    low_cnt_nxt_s = 4'd0;
    if (one_s) begin
      if ((low_cnt_r != 4'd0) && (idx_s == prev_idx_r)) begin
        if (low_cnt_r >= SETTLE_C) begin
          low_cnt_nxt_s = SETTLE_C;
        end else begin
          low_cnt_nxt_s = low_cnt_r + 4'd1;
        end
      end else begin
        low_cnt_nxt_s = 4'd1;
      end
    end else begin
      low_cnt_nxt_s = 4'd0;
    end
  end

  // A held anode disarms after its capture and re-arms only on a blank cycle.
  always_comb begin
    capture_s   = one_s && armed_r && (low_cnt_nxt_s == SETTLE_C);
    armed_nxt_s = armed_r;
    if (multi_s) begin
      armed_nxt_s = 1'b0;
    end else if (!one_s) begin
      armed_nxt_s = 1'b1;
    end else if (capture_s) begin
      armed_nxt_s = 1'b0;
    end else begin
      armed_nxt_s = armed_r;
    end
  end

  // Saturating stall counter increment.
  always_comb begin
    if (tmo_r == {TW{1'b1}}) begin
      tmo_inc_s = tmo_r;
    end else begin
      tmo_inc_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Frame FSM; priority is overlap, then capture, then stall timeout.
  always_comb begin
    state_nxt_s   = state_r;
    expect_nxt_s  = expect_r;
    tmo_nxt_s     = tmo_r;
    slot3_nxt_s   = slot3_r;
    slot2_nxt_s   = slot2_r;
    slot1_nxt_s   = slot1_r;
    digits_nxt_s  = digits_r;
    valid_nxt_s   = 1'b0;
    overlap_nxt_s = 1'b0;
    order_nxt_s   = 1'b0;
    timeout_nxt_s = 1'b0;
    if (multi_s) begin
      overlap_nxt_s = 1'b1;
      state_nxt_s   = ST_HUNT;
      tmo_nxt_s     = '0;
    end else if (capture_s) begin
      tmo_nxt_s = '0;
      if (state_r == ST_HUNT) begin
        if (idx_s == D3) begin
          slot3_nxt_s  = char;
          state_nxt_s  = ST_COLLECT;
          expect_nxt_s = D2;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end else if (idx_s == expect_r) begin
        case (expect_r)
          D2: begin
            slot2_nxt_s  = char;
            expect_nxt_s = D1;
          end
          D1: begin
            slot1_nxt_s  = char;
            expect_nxt_s = D0;
          end
          D0: begin
            digits_nxt_s = {slot3_r, slot2_r, slot1_r, char};
            valid_nxt_s  = 1'b1;
            state_nxt_s  = ST_HUNT;
            expect_nxt_s = D3;
          end
          default: begin
            state_nxt_s  = ST_HUNT;
            expect_nxt_s = D3;
          end
        endcase
      end else begin
        order_nxt_s = 1'b1;
        if (idx_s == D3) begin
          slot3_nxt_s  = char;
          state_nxt_s  = ST_COLLECT;
          expect_nxt_s = D2;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
    end else if (state_r == ST_COLLECT) begin
      if (tmo_inc_s == TMO_C) begin
        timeout_nxt_s = 1'b1;
        state_nxt_s   = ST_HUNT;
        tmo_nxt_s     = '0;
      end else begin
        tmo_nxt_s = tmo_inc_s;
      end
    end else begin
      tmo_nxt_s = '0;
    end
  end

  // State, counter, slot and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      low_cnt_r  <= 4'd0;
      prev_idx_r <= D0;
      armed_r    <= 1'b1;
      state_r    <= ST_HUNT;
      expect_r   <= D3;
      tmo_r      <= '0;
      slot3_r    <= 4'd0;
      slot2_r    <= 4'd0;
      slot1_r    <= 4'd0;
      digits_r   <= 16'h0000;
      valid_r    <= 1'b0;
      overlap_r  <= 1'b0;
      order_r    <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      low_cnt_r  <= low_cnt_nxt_s;
      prev_idx_r <= idx_s;
      armed_r    <= armed_nxt_s;
      state_r    <= state_nxt_s;
      expect_r   <= expect_nxt_s;
      tmo_r      <= tmo_nxt_s;
      slot3_r    <= slot3_nxt_s;
      slot2_r    <= slot2_nxt_s;
      slot1_r    <= slot1_nxt_s;
      digits_r   <= digits_nxt_s;
      valid_r    <= valid_nxt_s;
      overlap_r  <= overlap_nxt_s;
      order_r    <= order_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  assign digits      = digits_r;
  assign frame_valid = valid_r;
  assign overlap_err = overlap_r;
  assign order_err   = order_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: table of digit scans driven through a
// reference model that queues expected pulses; a monitor pops and compares.
module tb_display_scan_capture;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  localparam int K_VALID = 0;
  localparam int K_OVL   = 1;
  localparam int K_ORD   = 2;
  localparam int K_TMO   = 3;
  localparam int K_NONE  = 4;

  logic        clk;
  logic        reset;
  logic        an3, an2, an1, an0;
  logic [3:0]  char_bus;
  logic [15:0] digits;
  logic        frame_valid, overlap_err, order_err, timeout_err;

  display_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .an3         (an3),
    .an2         (an2),
    .an1         (an1),
    .an0         (an0),
    .char        (char_bus),
    .digits      (digits),
    .frame_valid (frame_valid),
    .overlap_err (overlap_err),
    .order_err   (order_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] d;
  } ev_t;

  typedef struct {
    int         idx;
    logic [3:0] ch;
    int         hold;
    int         gap;
  } scan_t;

  ev_t         exp_q[$];
  int          vcyc[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          started = 1'b0;
  logic [15:0] mon_digits = 16'h0000;

  // reference model state
  int          m_state = 0;
  int          m_exp   = 3;
  int          m_tmo   = 0;
  logic [3:0]  m_slot [4];
  logic [15:0] m_digits = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic m_reset();
    m_state  = 0;
    m_exp    = 3;
    m_tmo    = 0;
    m_digits = 16'h0000;
    for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
  endtask

  task automatic m_edges(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_state == 1) begin
        m_tmo++;
        if (m_tmo >= TIMEOUT) begin
          push(K_TMO, 16'h0000);
          m_state = 0;
          m_tmo   = 0;
        end
      end else begin
        m_tmo = 0;
      end
    end
  endtask

  task automatic m_capture(input int idx, input logic [3:0] ch);
    m_tmo = 0;
    if (m_state == 0) begin
      if (idx == 3) begin
        m_slot[3] = ch;
        m_state   = 1;
        m_exp     = 2;
      end
    end else if (idx == m_exp) begin
      if (idx == 0) begin
        m_digits = {m_slot[3], m_slot[2], m_slot[1], ch};
        push(K_VALID, m_digits);
        m_state = 0;
      end else begin
        m_slot[idx] = ch;
        m_exp       = m_exp - 1;
      end
    end else begin
      push(K_ORD, 16'h0000);
      if (idx == 3) begin
        m_slot[3] = ch;
        m_exp     = 2;
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [3:0] ch);
    {an3, an2, an1, an0} = an;
    char_bus = ch;
    @(posedge clk);
    #1;
  endtask

  // hold==0 means a pure blank interval of gap cycles
  task automatic scan(input int idx, input logic [3:0] ch, input int hold, input int gap);
    logic [3:0] a;
    if (hold >= SETTLE) begin
      m_edges(SETTLE - 1);
      m_capture(idx, ch);
      m_edges(hold - SETTLE + gap);
    end else begin
      m_edges(hold + gap);
    end
    a = 4'b0001 << idx;
    a = ~a;
    for (int i = 0; i < hold; i++) step(a, ch);
    for (int i = 0; i < gap; i++) step(4'hF, 4'h0);
  endtask

  task automatic frame(input logic [15:0] w);
    scan(3, w[15:12], 2, 2);
    scan(2, w[11:8], 2, 2);
    scan(1, w[7:4], 2, 2);
    scan(0, w[3:0], 2, 2);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    step(4'hF, 4'h0);
    reset = 1'b0;
    m_reset();
    mon_digits = 16'h0000;
    @(negedge clk);
    chk({name, "_digits"}, {16'h0, digits}, 32'h0);
    chk({name, "_pulses"}, {28'h0, frame_valid, overlap_err, order_err, timeout_err}, 32'h0);
  endtask

  // Output monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    int  n;
    int  k;
    ev_t e;
    cyc++;
    if (started) begin
      n = int'(frame_valid) + int'(overlap_err) + int'(order_err) + int'(timeout_err);
      chk("one_pulse_per_cycle", {31'h0, n > 1}, 32'h0);
      if (n >= 1) begin
        k = frame_valid ? K_VALID : overlap_err ? K_OVL : order_err ? K_ORD : K_TMO;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", k, K_NONE);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", k, e.kind);
          if (e.kind == K_VALID) begin
            mon_digits = e.d;
          end
          if (k == K_VALID) begin
            vcyc.push_back(cyc);
          end
        end
      end
      chk("digits", {16'h0, digits}, {16'h0, mon_digits});
    end
  end

  scan_t tbl[$];

  initial begin
    // 1: standard scans, two frames 0,1,A,F
    for (int f = 0; f < 2; f++) begin
      tbl.push_back('{3, 4'h0, 2, 2});
      tbl.push_back('{2, 4'h1, 2, 2});
      tbl.push_back('{1, 4'hA, 2, 2});
      tbl.push_back('{0, 4'hF, 2, 2});
    end
    // 2: digit 2 glitches for one cycle, frame stalls into timeout
    tbl.push_back('{3, 4'h9, 2, 2});
    tbl.push_back('{2, 4'h8, 1, 2});
    tbl.push_back('{0, 4'h0, 0, 70});
    // 4: order 3,1 then a full frame
    tbl.push_back('{3, 4'h1, 2, 2});
    tbl.push_back('{1, 4'h2, 2, 2});
    tbl.push_back('{3, 4'hC, 2, 2});
    tbl.push_back('{2, 4'hD, 2, 2});
    tbl.push_back('{1, 4'hE, 2, 2});
    tbl.push_back('{0, 4'hB, 2, 2});
    // 5: an2 held 6 cycles with char 7
    tbl.push_back('{3, 4'h4, 2, 2});
    tbl.push_back('{2, 4'h7, 6, 2});
    tbl.push_back('{1, 4'h5, 2, 2});
    tbl.push_back('{0, 4'h6, 2, 2});

    m_reset();
    {an3, an2, an1, an0} = 4'hF;
    char_bus = 4'h0;
    reset = 1'b1;
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_digits", {16'h0, digits}, 32'h0);
    chk("reset_pulses", {28'h0, frame_valid, overlap_err, order_err, timeout_err}, 32'h0);
    started = 1'b1;
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      scan(tbl[i].idx, tbl[i].ch, tbl[i].hold, tbl[i].gap);
      if (i == 7) begin
        chk("t1_digits", {16'h0, digits}, 32'h01AF);
        chk("t1_valid_count", vcyc.size(), 2);
        if (vcyc.size() >= 2) chk("t1_valid_period", vcyc[1] - vcyc[0], 16);
      end
      if (i == 10) chk("t2_digits_kept", {16'h0, digits}, 32'h01AF);
      if (i == 16) chk("t4_digits", {16'h0, digits}, 32'hCDEB);
      if (i == 20) chk("t5_digits", {16'h0, digits}, 32'h4756);
    end

    // 3: overlap of an3 and an1 mid-frame, then a clean frame
    scan(3, 4'h9, 2, 2);
    scan(2, 4'h9, 2, 2);
    push(K_OVL, 16'h0000);
    m_state = 0;
    m_tmo   = 0;
    step(4'b0101, 4'h9);
    m_edges(2);
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    frame(16'h2345);
    chk("t3_digits", {16'h0, digits}, 32'h2345);

    // 6: reset after digit 2 captured, then a full frame
    scan(3, 4'h6, 2, 2);
    scan(2, 4'h6, 2, 2);
    do_reset("t6_reset");
    frame(16'h1234);
    chk("t6_digits", {16'h0, digits}, 32'h1234);

    for (int i = 0; i < 5; i++) step(4'hF, 4'h0);
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
